sc_stream_generator: RTL and testbench

Binary-to-stochastic converter that sits directly upstream of the stochastic-to-binary reconversion stage. It accepts an unsigned binary magnitude through a valid/ready handshake and serially generates a unipolar stochastic bitstream of length L = 2^WIDTH by comparing the magnitude against a per-cycle random/quasi-random source. It then presents the completed L-bit stream vector, plus its ones count, to the downstream consumer through a second valid/ready handshake.

---
 rtl/sc_pkg.sv | 50 +++++
 rtl/sc_stream_generator_if.sv | 29 ++
 rtl/sc_rng.sv | 33 +++
 rtl/sc_stream_generator.sv | 88 ++++++++
 tb/tb_sc_stream_generator.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/sc_pkg.sv
// Shared types and helpers for the binary-to-stochastic stream generator.
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Maximal-length Fibonacci feedback masks (bit n-1 set for tap n), WIDTH 3..8.
    localparam logic [7:0] LFSR_TAPS_3 = 8'h06; // x^3 + x^2 + 1
    localparam logic [7:0] LFSR_TAPS_4 = 8'h0C; // x^4 + x^3 + 1
    localparam logic [7:0] LFSR_TAPS_5 = 8'h14; // x^5 + x^3 + 1
    localparam logic [7:0] LFSR_TAPS_6 = 8'h30; // x^6 + x^5 + 1
    localparam logic [7:0] LFSR_TAPS_7 = 8'h60; // x^7 + x^6 + 1
    localparam logic [7:0] LFSR_TAPS_8 = 8'hB8; // x^8 + x^6 + x^5 + x^4 + 1

    function automatic logic [7:0] lfsr_taps(input int width);
        case (width)
            3:       return LFSR_TAPS_3;
            4:       return LFSR_TAPS_4;
            5:       return LFSR_TAPS_5;
            6:       return LFSR_TAPS_6;
            7:       return LFSR_TAPS_7;
            default: return LFSR_TAPS_8;
        endcase
    endfunction

    // Reverse the low 'width' bits of x; upper result bits are zero.
    function automatic logic [7:0] bitrev(input logic [7:0] x, input int width);
        logic [7:0] res;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < width) begin
                res = (res << 1) | ((x >> i) & 8'h01);
            end
        end
        return res;
    endfunction

    // One Fibonacci step: shift left, XOR of tapped bits enters at bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s, input int width);
        logic       fb;
        logic [7:0] mask;
        fb   = ^(s & lfsr_taps(width));
        mask = 8'hFF >> (8 - width);
        return ((s << 1) | {7'b0, fb}) & mask;
    endfunction

endpackage

// File: rtl/sc_stream_generator_if.sv
// Input/output handshake bundle of the stochastic stream generator.
interface sc_stream_generator_if #(
    parameter int WIDTH = 4
);
    localparam int L = 1 << WIDTH;

    logic [WIDTH:0]   in_value;
    logic             in_valid;
    logic             in_ready;
    logic             sc_bit;
    logic             sc_bit_valid;
    logic [L-1:0]     sc_stream;
    logic [WIDTH:0]   ones_count;
    logic             out_valid;
    logic             out_ready;

    // Generator side.
    modport slave (
        input  in_value, in_valid, out_ready,
        output in_ready, sc_bit, sc_bit_valid, sc_stream, ones_count, out_valid
    );

    // Producer/consumer side.
    modport master (
        output in_value, in_valid, out_ready,
        input  in_ready, sc_bit, sc_bit_valid, sc_stream, ones_count, out_valid
    );

endinterface

// File: rtl/sc_rng.sv
// Per-cycle comparison source: bit-reversed counter or Fibonacci LFSR.
module sc_rng
    import sc_pkg::*;
#(
    parameter int          WIDTH   = 4,
    parameter int          RNG_VDC = 1,
    parameter int unsigned SEED    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_cnt,
    input  logic             i_advance,
    output logic [WIDTH-1:0] o_r
);

    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] w_vdc;

    assign w_vdc = WIDTH'(bitrev(8'(i_cnt), WIDTH));

    // LFSR steps only while a stream is being generated; it is never reseeded between streams.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_lfsr <= WIDTH'(SEED);
        end else if (i_advance) begin
            r_lfsr <= WIDTH'(lfsr_next(8'(r_lfsr), WIDTH));
        end
    end

    assign o_r = (RNG_VDC != 0) ? w_vdc : r_lfsr;

endmodule

// File: rtl/sc_stream_generator.sv
// Binary-to-stochastic converter: latches a magnitude, emits L serial bits, then holds the stream.
module sc_stream_generator
    import sc_pkg::*;
#(
    parameter int          WIDTH   = 4,
    parameter int          RNG_VDC = 1,
    parameter int unsigned SEED    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sc_stream_generator_if.slave  bus
);

    localparam int L = 1 << WIDTH;

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH:0]   r_val;
    logic [L-1:0]     r_stream;
    logic [WIDTH:0]   r_ones;

    logic [WIDTH-1:0] w_r;
    logic [WIDTH:0]   w_sat;
    logic             w_gen;
    logic             w_bit;

    sc_rng #(
        .WIDTH   (WIDTH),
        .RNG_VDC (RNG_VDC),
        .SEED    (SEED)
    ) u_rng (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_cnt     (r_cnt),
        .i_advance (w_gen),
        .o_r       (w_r)
    );

    assign w_gen = (r_state == GEN);
    assign w_sat = (bus.in_value > (WIDTH+1)'(L)) ? (WIDTH+1)'(L) : bus.in_value;
    // Zero-extended compare lets val = L produce an all-ones stream.
    assign w_bit = w_gen && ({1'b0, w_r} < r_val);

    // Handshake FSM plus serial accumulation of the stream and its ones count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_val    <= '0;
            r_stream <= '0;
            r_ones   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_val    <= w_sat;
                        r_cnt    <= '0;
                        r_stream <= '0;
                        r_ones   <= '0;
                        r_state  <= GEN;
                    end
                end
                GEN: begin
                    r_stream[r_cnt] <= w_bit;
                    r_ones          <= r_ones + (WIDTH+1)'(w_bit);
                    r_cnt           <= r_cnt + WIDTH'(1);
                    if (r_cnt == WIDTH'(L - 1)) begin
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready     = (r_state == IDLE);
    assign bus.out_valid    = (r_state == HOLD);
    assign bus.sc_bit_valid = w_gen;
    assign bus.sc_bit       = w_bit;
    assign bus.sc_stream    = r_stream;
    assign bus.ones_count   = r_ones;

endmodule

// File: tb/tb_sc_stream_generator.sv
// Drives a counter-source and an LFSR-source generator in lockstep and checks both against a reference model.
module tb_sc_stream_generator;

    localparam int WIDTH = 4;
    localparam int L     = 16;
    localparam int SEED  = 1;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [WIDTH:0] in_value = '0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;

    int errors = 0;
    int checks = 0;
    int lfsr_model = SEED;

    always #5 clk = ~clk;

    sc_stream_generator_if #(.WIDTH(WIDTH)) if_vdc ();
    sc_stream_generator_if #(.WIDTH(WIDTH)) if_lfsr ();

    assign if_vdc.in_value   = in_value;
    assign if_vdc.in_valid   = in_valid;
    assign if_vdc.out_ready  = out_ready;
    assign if_lfsr.in_value  = in_value;
    assign if_lfsr.in_valid  = in_valid;
    assign if_lfsr.out_ready = out_ready;

    sc_stream_generator #(.WIDTH(WIDTH), .RNG_VDC(1), .SEED(SEED)) u_vdc (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_vdc)
    );

    sc_stream_generator #(.WIDTH(WIDTH), .RNG_VDC(0), .SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_lfsr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Van der Corput threshold for cycle k: the 4-bit index read back to front.
    function automatic int vdc_r(input int k);
        int r;
        r = 0;
        for (int i = 0; i < WIDTH; i++) begin
            r = r + (((k >> i) & 1) << (WIDTH - 1 - i));
        end
        return r;
    endfunction

    // Recurrence of x^4 + x^3 + 1: new bit = s3 xor s2, shifted in at the bottom.
    function automatic int lfsr_step(input int s);
        return ((s << 1) & 15) | (((s >> 3) ^ (s >> 2)) & 1);
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, " vdc in_ready"},      32'(if_vdc.in_ready), 1);
        check({tag, " vdc out_valid"},     32'(if_vdc.out_valid), 0);
        check({tag, " vdc sc_bit_valid"},  32'(if_vdc.sc_bit_valid), 0);
        check({tag, " vdc sc_bit"},        32'(if_vdc.sc_bit), 0);
        check({tag, " vdc sc_stream"},     32'(if_vdc.sc_stream), 0);
        check({tag, " vdc ones_count"},    32'(if_vdc.ones_count), 0);
        check({tag, " lfsr in_ready"},     32'(if_lfsr.in_ready), 1);
        check({tag, " lfsr out_valid"},    32'(if_lfsr.out_valid), 0);
        check({tag, " lfsr sc_bit_valid"}, 32'(if_lfsr.sc_bit_valid), 0);
        check({tag, " lfsr sc_bit"},       32'(if_lfsr.sc_bit), 0);
        check({tag, " lfsr sc_stream"},    32'(if_lfsr.sc_stream), 0);
        check({tag, " lfsr ones_count"},   32'(if_lfsr.ones_count), 0);
    endtask

    // One full transaction on both generators; abort_at >= 0 pulls reset in that GEN cycle.
    task automatic run_stream(input int value, input int hold, input int abort_at);
        logic [L-1:0] exp_v;
        logic [L-1:0] exp_l;
        int           ones_v;
        int           ones_l;
        int           val;
        int           s;

        val    = (value > L) ? L : value;
        exp_v  = '0;
        exp_l  = '0;
        ones_v = 0;
        ones_l = 0;
        s      = lfsr_model;
        for (int k = 0; k < L; k++) begin
            exp_v[k] = (vdc_r(k) < val);
            exp_l[k] = (s < val);
            ones_v   = ones_v + int'(exp_v[k]);
            ones_l   = ones_l + int'(exp_l[k]);
            s        = lfsr_step(s);
        end

        @(negedge clk);
        check($sformatf("v%0d vdc in_ready idle", value), 32'(if_vdc.in_ready), 1);
        check($sformatf("v%0d lfsr in_ready idle", value), 32'(if_lfsr.in_ready), 1);
        in_value = (WIDTH+1)'(value);
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);

        for (int k = 0; k < L; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("v%0d vdc bit%0d", value, k), {30'(0), if_vdc.sc_bit_valid, if_vdc.sc_bit}, {30'(0), 1'b1, exp_v[k]});
            check($sformatf("v%0d lfsr bit%0d", value, k), {30'(0), if_lfsr.sc_bit_valid, if_lfsr.sc_bit}, {30'(0), 1'b1, exp_l[k]});
            if (k == L - 1 || k == 0) begin
                check($sformatf("v%0d gen%0d flags", value, k),
                      {28'(0), if_vdc.out_valid, if_vdc.in_ready, if_lfsr.out_valid, if_lfsr.in_ready}, 0);
            end
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_idle_outputs($sformatf("reset in gen%0d", k));
                lfsr_model = SEED;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        lfsr_model = s;

        @(negedge clk);
        check($sformatf("v%0d vdc out_valid", value), 32'(if_vdc.out_valid), 1);
        check($sformatf("v%0d lfsr out_valid", value), 32'(if_lfsr.out_valid), 1);
        check($sformatf("v%0d vdc stream", value), 32'(if_vdc.sc_stream), 32'(exp_v));
        check($sformatf("v%0d vdc ones", value), 32'(if_vdc.ones_count), ones_v);
        check($sformatf("v%0d vdc exact", value), 32'(if_vdc.ones_count), val);
        check($sformatf("v%0d lfsr stream", value), 32'(if_lfsr.sc_stream), 32'(exp_l));
        check($sformatf("v%0d lfsr ones", value), 32'(if_lfsr.ones_count), ones_l);
        check($sformatf("v%0d hold bitvalid", value), {30'(0), if_vdc.sc_bit_valid, if_lfsr.sc_bit_valid}, 0);

        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_value = (WIDTH+1)'($urandom_range(0, 31));
            @(negedge clk);
            check($sformatf("v%0d hold%0d vdc", value, h),
                  {if_vdc.out_valid, if_vdc.in_ready, 5'(if_vdc.ones_count), if_vdc.sc_stream},
                  {1'b1, 1'b0, 5'(ones_v), exp_v});
            check($sformatf("v%0d hold%0d lfsr", value, h),
                  {if_lfsr.out_valid, if_lfsr.in_ready, 5'(if_lfsr.ones_count), if_lfsr.sc_stream},
                  {1'b1, 1'b0, 5'(ones_l), exp_l});
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check($sformatf("v%0d release", value),
              {28'(0), if_vdc.in_ready, if_vdc.out_valid, if_lfsr.in_ready, if_lfsr.out_valid},
              {28'(0), 1'b1, 1'b0, 1'b1, 1'b0});
        out_ready = 1'b0;
    endtask

    initial begin
        #2;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner values.
        run_stream(5, 0, -1);
        run_stream(0, 0, -1);
        run_stream(16, 0, -1);
        run_stream(20, 3, -1);

        // Exactness sweep of the counter source.
        for (int v = 0; v <= L; v++) begin
            run_stream(v, 0, -1);
        end

        // Long stall with in_valid noise while the stream is held.
        run_stream(int'($urandom_range(0, 16)), 10, -1);

        // Random magnitudes, including saturating ones, with random stalls.
        for (int n = 0; n < 8; n++) begin
            run_stream(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)), -1);
        end

        // Reset in the middle of generation, then restart from SEED.
        run_stream(9, 0, 7);
        run_stream(3, 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
